// File: rtl/enc8b10b_lanes_if.sv
// Stream bundle for enc8b10b_lanes: byte input side (slave)
// and 10-bit symbol output side (master).
interface enc8b10b_lanes_if #(
   parameter int LANES = 2
);
   logic                s_valid;
   logic                s_ready;
   logic [8*LANES-1:0]  s_data;
   logic [LANES-1:0]    s_datak;
   logic                m_valid;
   logic                m_ready;
   logic [10*LANES-1:0] m_data;
   logic [LANES-1:0]    code_err;
   logic [LANES-1:0]    rd_state;
   logic                skp_active;

   modport slave (
      input  s_valid,
      input  s_data,
      input  s_datak,
      output s_ready
   );

   modport master (
      output m_valid,
      output m_data,
      output code_err,
      output rd_state,
      output skp_active,
      input  m_ready
   );
endinterface

// File: rtl/enc8b10b_lanes.sv
// Multi-lane 8b/10b encoder with one output register and optional
// comma/skip insertion, compiled in with ENC8B10B_SKP_INSERT_EN.
module enc8b10b_lanes #(
   parameter int LANES        = 2,
   parameter int REVERSE      = 0,
   parameter int DISP_INIT    = 0,
   parameter int SKP_INTERVAL = 1180,
   parameter int SKP_LEN      = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en_n,
   enc8b10b_lanes_if.slave  s,
   enc8b10b_lanes_if.master m
);
   localparam bit CFG_OK = (SKP_INTERVAL >= 2) && (SKP_LEN >= 1)
                        && (SKP_LEN <= 4) && (LANES >= 1) && (LANES <= 8);

   if (!CFG_OK) begin : g_cfg_err
      $error("enc8b10b_lanes: parameter out of range");
   end

   function automatic logic [5:0] tab6(input logic [4:0] x);
      logic [5:0] c;
      case (x)
         5'd0:    c = 6'b100111;
         5'd1:    c = 6'b011101;
         5'd2:    c = 6'b101101;
         5'd3:    c = 6'b110001;
         5'd4:    c = 6'b110101;
         5'd5:    c = 6'b101001;
         5'd6:    c = 6'b011001;
         5'd7:    c = 6'b111000;
         5'd8:    c = 6'b111001;
         5'd9:    c = 6'b100101;
         5'd10:   c = 6'b010101;
         5'd11:   c = 6'b110100;
         5'd12:   c = 6'b001101;
         5'd13:   c = 6'b101100;
         5'd14:   c = 6'b011100;
         5'd15:   c = 6'b010111;
         5'd16:   c = 6'b011011;
         5'd17:   c = 6'b100011;
         5'd18:   c = 6'b010011;
         5'd19:   c = 6'b110010;
         5'd20:   c = 6'b001011;
         5'd21:   c = 6'b101010;
         5'd22:   c = 6'b011010;
         5'd23:   c = 6'b111010;
         5'd24:   c = 6'b110011;
         5'd25:   c = 6'b100110;
         5'd26:   c = 6'b010110;
         5'd27:   c = 6'b110110;
         5'd28:   c = 6'b001110;
         5'd29:   c = 6'b101110;
         5'd30:   c = 6'b011110;
         default: c = 6'b101011;
      endcase
      return c;
   endfunction

   // Tables hold the code for RD- entering the sub-block (a/f in the MSB).
   function automatic logic [3:0] tab4(input logic [2:0] y,
                                       input logic k,
                                       input logic a7);
      logic [3:0] c;
      case (y)
         3'd0:    c = 4'b1011;
         3'd1:    c = k ? 4'b0110 : 4'b1001;
         3'd2:    c = k ? 4'b1010 : 4'b0101;
         3'd3:    c = 4'b1100;
         3'd4:    c = 4'b1101;
         3'd5:    c = k ? 4'b0101 : 4'b1010;
         3'd6:    c = k ? 4'b1001 : 4'b0110;
         default: c = (k || a7) ? 4'b0111 : 4'b1110;
      endcase
      return c;
   endfunction

   // Returns {code_err, rd_out, abcdei fghj}.
   function automatic logic [11:0] enc(input logic [7:0] d,
                                       input logic k,
                                       input logic rd);
      logic [4:0] x;
      logic [2:0] y;
      logic       kv;
      logic [5:0] c6;
      logic [3:0] c4;
      logic       u6;
      logic       u4;
      logic       rd6;
      logic       a7;
      x  = d[4:0];
      y  = d[7:5];
      kv = (x == 5'd28)
        || ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27)
                         || (x == 5'd29) || (x == 5'd30)));
      if (k && !kv) begin
         x = 5'd28;
         y = 3'd5;
      end
      c6 = (k && (x == 5'd28)) ? 6'b001111 : tab6(x);
      u6 = ($countones(c6) != 3);
      if (rd && (u6 || (x == 5'd7)))
         c6 = ~c6;
      rd6 = rd ^ u6;
      a7  = (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20)))
         || ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
      c4 = tab4(y, k, a7);
      u4 = ($countones(c4) != 2);
      if (rd6 && (k || u4 || (y == 3'd3)))
         c4 = ~c4;
      return {k && !kv, rd6 ^ u4, c6, c4};
   endfunction

   logic                run;
   logic                m_valid_r;
   logic [10*LANES-1:0] m_data_r;
   logic [LANES-1:0]    err_r;
   logic [LANES-1:0]    rd_r;
   logic                skp_pending;
   logic                skp_first;
   logic                slot;
   logic [10*LANES-1:0] e_data;
   logic [LANES-1:0]    e_err;
   logic [LANES-1:0]    e_rd;

   // An output slot opens when enabled and the register is free or draining.
   assign slot = run && !en_n && (!m_valid_r || m.m_ready);

   always_comb begin
      logic [7:0]  d;
      logic        k;
      logic [11:0] r;
      d      = '0;
      k      = 1'b0;
      r      = '0;
      e_data = '0;
      e_err  = '0;
      e_rd   = '0;
      for (int i = 0; i < LANES; i++) begin
         d = skp_pending ? (skp_first ? 8'hBC : 8'h1C)
                         : s.s_data[8*i +: 8];
         k = skp_pending | s.s_datak[i];
         r = enc(d, k, rd_r[i]);
         e_err[i] = r[11];
         e_rd[i]  = r[10];
         for (int b = 0; b < 10; b++)
            e_data[10*i + b] = (REVERSE != 0) ? r[b] : r[9-b];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run       <= 1'b0;
         m_valid_r <= 1'b0;
         m_data_r  <= '0;
         err_r     <= '0;
         rd_r      <= {LANES{DISP_INIT[0]}};
      end else begin
         run <= 1'b1;
         if (slot && (skp_pending || s.s_valid)) begin
            m_valid_r <= 1'b1;
            m_data_r  <= e_data;
            err_r     <= e_err;
            rd_r      <= e_rd;
         end else if (slot) begin
            m_valid_r <= 1'b0;
         end
      end
   end

`ifdef ENC8B10B_SKP_INSERT_EN
   localparam int CW = $clog2(SKP_INTERVAL + 1);

   logic [CW-1:0] skp_cnt;
   logic [2:0]    skp_idx;
   logic          skp_act_r;

   assign skp_first = (skp_idx == 3'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         skp_cnt     <= '0;
         skp_pending <= 1'b0;
         skp_idx     <= '0;
         skp_act_r   <= 1'b0;
      end else if (slot) begin
         if (skp_pending) begin
            skp_act_r <= 1'b1;
            if (skp_idx == 3'(SKP_LEN)) begin
               skp_pending <= 1'b0;
               skp_idx     <= '0;
            end else begin
               skp_idx <= skp_idx + 3'd1;
            end
         end else begin
            skp_act_r <= 1'b0;
            if (s.s_valid) begin
               if (skp_cnt == CW'(SKP_INTERVAL - 1)) begin
                  skp_cnt     <= '0;
                  skp_pending <= 1'b1;
               end else begin
                  skp_cnt <= skp_cnt + CW'(1);
               end
            end
         end
      end
   end

   assign m.skp_active = m_valid_r && skp_act_r && !en_n;
`else
   assign skp_pending  = 1'b0;
   assign skp_first    = 1'b0;
   assign m.skp_active = 1'b0;
`endif

   assign s.s_ready  = slot && !skp_pending;
   assign m.m_valid  = m_valid_r && !en_n;
   assign m.m_data   = en_n ? '0 : m_data_r;
   assign m.code_err = (m_valid_r && !en_n) ? err_r : '0;
   assign m.rd_state = rd_r;
endmodule

// File: tb/tb_enc8b10b_lanes.sv
// Scoreboard bench for enc8b10b_lanes (2 lanes, skip interval 4,
// skip length 2); skip checks follow ENC8B10B_SKP_INSERT_EN.
module tb_enc8b10b_lanes;
   localparam int L = 2;

   typedef struct packed {
      logic [19:0] d;
      logic [1:0]  e;
      logic [1:0]  rd;
      logic        sk;
   } exp_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic en_n    = 1'b0;
   exp_t sb[$];
   int   total   = 0;
   int   bad     = 0;

   always #5 clk = ~clk;

   enc8b10b_lanes_if #(.LANES(L)) bus ();

   enc8b10b_lanes #(
      .LANES(L), .REVERSE(0), .DISP_INIT(0),
      .SKP_INTERVAL(4), .SKP_LEN(2)
   ) dut (
      .clk(clk), .reset_n(reset_n), .en_n(en_n),
      .s(bus), .m(bus)
   );

   // Literals are written a..j left to right; m_data[0] carries a.
   function automatic logic [9:0] sym(input logic [9:0] aj);
      logic [9:0] r;
      for (int b = 0; b < 10; b++) r[b] = aj[9-b];
      return r;
   endfunction

   function automatic exp_t mk(input logic [9:0] l1, input logic [9:0] l0,
                               input logic [1:0] e, input logic [1:0] rd,
                               input logic sk);
      exp_t x;
      x.d  = {sym(l1), sym(l0)};
      x.e  = e;
      x.rd = rd;
      x.sk = sk;
      return x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (bus.m_valid && bus.m_ready) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_word: got %h want none", bus.m_data);
            end else begin
               e = sb.pop_front();
               chk("m_data", 32'(bus.m_data), 32'(e.d));
               chk("code_err", 32'(bus.code_err), 32'(e.e));
               chk("rd_state", 32'(bus.rd_state), 32'(e.rd));
               chk("skp_active", 32'(bus.skp_active), 32'(e.sk));
            end
         end
      end
   end

   task automatic send(input logic [15:0] d, input logic [1:0] k,
                       input exp_t e);
      bit done;
      done = 0;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         bus.s_valid = 1'b1;
         bus.s_data  = d;
         bus.s_datak = k;
         #1;
         if (bus.s_ready) begin
            sb.push_back(e);
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      bus.s_valid = 1'b0;
      if (!done) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got s_ready=0 want 1");
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
      chk("drain_left", 32'(sb.size()), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n     = 1'b0;
      bus.s_valid = 1'b0;
      sb.delete();
      #1;
      chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
      chk("rst_m_data", 32'(bus.m_data), 32'd0);
      chk("rst_code_err", 32'(bus.code_err), 32'd0);
      chk("rst_skp_active", 32'(bus.skp_active), 32'd0);
      chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
      chk("rst_rd_state", 32'(bus.rd_state), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("rel_s_ready_pre", 32'(bus.s_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("rel_s_ready_post", 32'(bus.s_ready), 32'd1);
   endtask

   localparam logic [9:0] K285N = 10'b0011111010;
   localparam logic [9:0] K285P = 10'b1100000101;
   localparam logic [9:0] K280P = 10'b1100001011;
   localparam logic [9:0] D215  = 10'b1010101010;

`ifdef ENC8B10B_SKP_INSERT_EN
   task automatic run_skip_seq();
      for (int i = 0; i < 4; i++)
         send(16'hB5B5, 2'b00, mk(D215, D215, 2'b00, 2'b00, 1'b0));
      sb.push_back(mk(K285N, K285N, 2'b00, 2'b11, 1'b1));
      sb.push_back(mk(K280P, K280P, 2'b00, 2'b11, 1'b1));
      sb.push_back(mk(K280P, K280P, 2'b00, 2'b11, 1'b1));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("skip_s_ready", 32'(bus.s_ready), 32'd0);
      end
      for (int i = 0; i < 2; i++)
         send(16'hB5B5, 2'b00, mk(D215, D215, 2'b00, 2'b11, 1'b0));
   endtask
`endif

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_datak = '0;
      bus.m_ready = 1'b1;
      do_reset();

      // K28.5 / D21.5, then illegal K and K27.7, then D0.0 / D10.2
      send(16'hB5BC, 2'b01, mk(D215, K285N, 2'b00, 2'b01, 1'b0));
      send(16'hFB00, 2'b11,
           mk(10'b1101101000, K285P, 2'b01, 2'b00, 1'b0));
      send(16'h4A00, 2'b00,
           mk(10'b0101010101, 10'b1001110100, 2'b00, 2'b00, 1'b0));
      drain();
      do_reset();

      // backpressure: W1 held for 5 cycles while W2 waits
      send(16'hBCB5, 2'b10, mk(K285N, D215, 2'b00, 2'b10, 1'b0));
      @(negedge clk);
      bus.m_ready = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = 16'h00BC;
      bus.s_datak = 2'b01;
      for (int i = 0; i < 5; i++) begin
         if (i != 0) @(negedge clk);
         #1;
         chk("stall_s_ready", 32'(bus.s_ready), 32'd0);
         chk("stall_m_valid", 32'(bus.m_valid), 32'd1);
         chk("stall_m_data", 32'(bus.m_data), 32'({sym(K285N), sym(D215)}));
         chk("stall_rd_state", 32'(bus.rd_state), 32'd2);
      end
      @(negedge clk);
      bus.m_ready = 1'b1;
      #1;
      chk("resume_s_ready", 32'(bus.s_ready), 32'd1);
      sb.push_back(mk(10'b0110001011, K285N, 2'b00, 2'b11, 1'b0));
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
      send(16'hBCB5, 2'b10, mk(K285P, D215, 2'b00, 2'b01, 1'b0));

      // enable pause holds the word and disparity
      @(negedge clk);
      en_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i != 0) @(negedge clk);
         #1;
         chk("dis_m_valid", 32'(bus.m_valid), 32'd0);
         chk("dis_m_data", 32'(bus.m_data), 32'd0);
         chk("dis_s_ready", 32'(bus.s_ready), 32'd0);
         chk("dis_rd_state", 32'(bus.rd_state), 32'd1);
      end
      @(negedge clk);
      en_n = 1'b0;
      drain();
      do_reset();

`ifdef ENC8B10B_SKP_INSERT_EN
      run_skip_seq();
      drain();
      do_reset();
      for (int i = 0; i < 4; i++)
         send(16'hB5B5, 2'b00, mk(D215, D215, 2'b00, 2'b00, 1'b0));
      sb.push_back(mk(K285N, K285N, 2'b00, 2'b11, 1'b1));
      sb.push_back(mk(K280P, K280P, 2'b00, 2'b11, 1'b1));
      sb.push_back(mk(K280P, K280P, 2'b00, 2'b11, 1'b1));
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("mid_skp_active", 32'(bus.skp_active), 32'd1);
      chk("mid_m_data", 32'(bus.m_data), 32'({sym(K280P), sym(K280P)}));
      do_reset();
      run_skip_seq();
`else
      for (int i = 0; i < 6; i++)
         send(16'hB5B5, 2'b00, mk(D215, D215, 2'b00, 2'b00, 1'b0));
      #1;
      chk("noskip_s_ready", 32'(bus.s_ready), 32'd1);
`endif
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
